// File: rtl/dram_arbiter_pkg.sv
// Shared constants for the DRAM port arbiter: grant sentinel, FSM encodings, ctrl width.
// Also holds a helper for sizing hart-index fields.
package dram_arbiter_pkg;

    localparam logic [31:0] DEF_GRANT_NONE = 32'hFFFF_FFFF;
    localparam int          CTRL_W         = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first requester after last_i, wrapping.
// valid_o is low when no request bit is set.
module dram_arbiter_rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    int   cand;
    logic found;

    always_comb begin
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        // Offset 1..N so the previous owner is examined last.
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_i) + k) % N;
            if (!found && req_i[IW'(cand)]) begin
                found = 1'b1;
                idx_o = IW'(cand);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter serialising whole transactions from NCORES MMUs onto one DRAM port.
// Grant is held from issue until the hart has had one cycle to capture read data.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int          NCORES     = 2,
    parameter logic [31:0] GRANT_NONE = DEF_GRANT_NONE
) (
    input  logic                     CLK,
    input  logic                     RST_X,
    input  logic [NCORES*32-1:0]     w_req_addr,
    input  logic [NCORES*32-1:0]     w_req_wdata,
    input  logic [NCORES*CTRL_W-1:0] w_req_ctrl,
    input  logic [NCORES-1:0]        w_req_we,
    input  logic [NCORES-1:0]        w_req_le,
    output logic [NCORES-1:0]        w_req_busy,
    output logic [31:0]              w_req_odata,
    output logic [31:0]              w_grant,
    output logic [31:0]              w_mem_addr,
    output logic [31:0]              w_mem_wdata,
    output logic [CTRL_W-1:0]        w_mem_ctrl,
    output logic                     w_mem_we,
    output logic                     w_mem_le,
    input  logic                     w_mem_busy,
    input  logic [31:0]              w_mem_odata,
    output logic [1:0]               dbg_state_o
);

    localparam int IW = idx_width(NCORES);

    logic [1:0]        state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [IW-1:0]     gnt_q, gnt_d;
    logic [31:0]       grant_q, grant_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic              we_q, we_d;
    logic              le_q, le_d;
    logic [31:0]       odata_q, odata_d;
    logic [NCORES-1:0] busy_q, busy_d;
    logic              seen_busy_q, seen_busy_d;
    logic              first_wait_q, first_wait_d;

    logic [NCORES-1:0] req;
    logic [31:0]       addr_arr  [NCORES];
    logic [31:0]       wdata_arr [NCORES];
    logic [CTRL_W-1:0] ctrl_arr  [NCORES];
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic              owned;

    assign req = w_req_we | w_req_le;

    for (genvar g = 0; g < NCORES; g++) begin : g_split
        assign addr_arr[g]  = w_req_addr[32*g +: 32];
        assign wdata_arr[g] = w_req_wdata[32*g +: 32];
        assign ctrl_arr[g]  = w_req_ctrl[CTRL_W*g +: CTRL_W];
    end

    dram_arbiter_rr_pick #(
        .N  (NCORES),
        .IW (IW)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (rr_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    always_comb begin
        state_d      = state_q;
        rr_d         = rr_q;
        gnt_d        = gnt_q;
        grant_d      = grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ctrl_d       = ctrl_q;
        we_d         = 1'b0;
        le_d         = 1'b0;
        odata_d      = odata_q;
        seen_busy_d  = seen_busy_q;
        first_wait_d = first_wait_q;
        busy_d       = '0;
        owned        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    addr_d  = addr_arr[pick_idx];
                    wdata_d = wdata_arr[pick_idx];
                    ctrl_d  = ctrl_arr[pick_idx];
                    // A hart raising both we and le is treated as a write.
                    we_d    = w_req_we[pick_idx];
                    le_d    = ~w_req_we[pick_idx] & w_req_le[pick_idx];
                    gnt_d   = pick_idx;
                    grant_d = 32'(pick_idx);
                    rr_d    = pick_idx;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                seen_busy_d  = 1'b0;
                first_wait_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                first_wait_d = 1'b0;
                if (seen_busy_q && !w_mem_busy) begin
                    odata_d = w_mem_odata;
                    state_d = ST_RELEASE;
                end else if (w_mem_busy || first_wait_q) begin
                    // Controller is silent after the first WAIT cycle: assume zero latency.
                    seen_busy_d = 1'b1;
                end
            end
            default: begin
                grant_d = GRANT_NONE;
                state_d = ST_IDLE;
            end
        endcase

        for (int i = 0; i < NCORES; i++) begin
            owned = (state_d != ST_IDLE) && (gnt_d == IW'(i));
            busy_d[i] = owned ? (state_d == ST_ISSUE || state_d == ST_WAIT) : req[i];
        end
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state_q      <= ST_IDLE;
            rr_q         <= IW'(NCORES - 1);
            gnt_q        <= '0;
            grant_q      <= GRANT_NONE;
            addr_q       <= '0;
            wdata_q      <= '0;
            ctrl_q       <= '0;
            we_q         <= 1'b0;
            le_q         <= 1'b0;
            odata_q      <= '0;
            busy_q       <= '0;
            seen_busy_q  <= 1'b0;
            first_wait_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            grant_q      <= grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ctrl_q       <= ctrl_d;
            we_q         <= we_d;
            le_q         <= le_d;
            odata_q      <= odata_d;
            busy_q       <= busy_d;
            seen_busy_q  <= seen_busy_d;
            first_wait_q <= first_wait_d;
        end
    end

    assign w_req_busy  = busy_q;
    assign w_req_odata = odata_q;
    assign w_grant     = grant_q;
    assign w_mem_addr  = addr_q;
    assign w_mem_wdata = wdata_q;
    assign w_mem_ctrl  = ctrl_q;
    assign w_mem_we    = we_q;
    assign w_mem_le    = le_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with two harts and a hand-driven controller.
// The bench plays the DRAM controller by driving w_mem_busy / w_mem_odata per step.
module tb_dram_arbiter;
    import dram_arbiter_pkg::*;

    localparam int N = 2;

    logic            CLK = 1'b0;
    logic            RST_X;
    logic [N*32-1:0] w_req_addr;
    logic [N*32-1:0] w_req_wdata;
    logic [N*3-1:0]  w_req_ctrl;
    logic [N-1:0]    w_req_we;
    logic [N-1:0]    w_req_le;
    logic [N-1:0]    w_req_busy;
    logic [31:0]     w_req_odata;
    logic [31:0]     w_grant;
    logic [31:0]     w_mem_addr;
    logic [31:0]     w_mem_wdata;
    logic [2:0]      w_mem_ctrl;
    logic            w_mem_we;
    logic            w_mem_le;
    logic            w_mem_busy;
    logic [31:0]     w_mem_odata;
    logic [1:0]      dbg_state;

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    dram_arbiter #(.NCORES(N)) dut (
        .CLK         (CLK),
        .RST_X       (RST_X),
        .w_req_addr  (w_req_addr),
        .w_req_wdata (w_req_wdata),
        .w_req_ctrl  (w_req_ctrl),
        .w_req_we    (w_req_we),
        .w_req_le    (w_req_le),
        .w_req_busy  (w_req_busy),
        .w_req_odata (w_req_odata),
        .w_grant     (w_grant),
        .w_mem_addr  (w_mem_addr),
        .w_mem_wdata (w_mem_wdata),
        .w_mem_ctrl  (w_mem_ctrl),
        .w_mem_we    (w_mem_we),
        .w_mem_le    (w_mem_le),
        .w_mem_busy  (w_mem_busy),
        .w_mem_odata (w_mem_odata),
        .dbg_state_o (dbg_state)
    );

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_hart(input int h, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] ctrl);
        w_req_addr[32*h +: 32]  = addr;
        w_req_wdata[32*h +: 32] = wd;
        w_req_ctrl[3*h +: 3]    = ctrl;
    endtask

    // Entered one step after an edge with the DUT in IDLE and requests already driven.
    task automatic txn(input int h, input logic is_we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] ctrl, input int nbusy,
                       input logic [31:0] rd, input logic drop, input string tag);
        logic [N-1:0] req;
        logic [N-1:0] hbit;
        int           waited;
        hbit = N'(1) << h;
        req  = w_req_we | w_req_le;
        tick;
        chk({tag, ".state_issue"}, 32'(dbg_state), 32'(ST_ISSUE));
        chk({tag, ".grant"}, w_grant, 32'(h));
        chk({tag, ".mem_we"}, 32'(w_mem_we), 32'(is_we));
        chk({tag, ".mem_le"}, 32'(w_mem_le), 32'(!is_we));
        chk({tag, ".mem_addr"}, w_mem_addr, addr);
        chk({tag, ".mem_wdata"}, w_mem_wdata, wd);
        chk({tag, ".mem_ctrl"}, 32'(w_mem_ctrl), 32'(ctrl));
        chk({tag, ".busy_issue"}, 32'(w_req_busy), 32'(req | hbit));
        if (drop) begin
            w_req_we[h] = 1'b0;
            w_req_le[h] = 1'b0;
        end
        tick;
        chk({tag, ".state_wait"}, 32'(dbg_state), 32'(ST_WAIT));
        chk({tag, ".strobes_off"}, 32'({w_mem_we, w_mem_le}), 32'h0);
        chk({tag, ".busy_wait"}, 32'(w_req_busy[h]), 32'h1);
        if (nbusy == 0) w_mem_odata = rd;
        else w_mem_busy = 1'b1;
        for (int k = 0; k < nbusy; k++) tick;
        w_mem_busy  = 1'b0;
        w_mem_odata = rd;
        waited = 0;
        do begin
            tick;
            waited++;
        end while (dbg_state != ST_RELEASE && waited < 8);
        chk({tag, ".wait_cycles"}, 32'(waited), (nbusy == 0) ? 32'd2 : 32'd1);
        chk({tag, ".state_release"}, 32'(dbg_state), 32'(ST_RELEASE));
        chk({tag, ".grant_release"}, w_grant, 32'(h));
        chk({tag, ".odata"}, w_req_odata, rd);
        chk({tag, ".busy_release"}, 32'(w_req_busy), 32'((w_req_we | w_req_le) & ~hbit));
        w_mem_odata = 32'h0;
        tick;
        chk({tag, ".state_idle"}, 32'(dbg_state), 32'(ST_IDLE));
        chk({tag, ".grant_none"}, w_grant, 32'hFFFF_FFFF);
    endtask

    initial begin
        RST_X       = 1'b0;
        w_req_addr  = '0;
        w_req_wdata = '0;
        w_req_ctrl  = '0;
        w_req_we    = '0;
        w_req_le    = '0;
        w_mem_busy  = 1'b0;
        w_mem_odata = '0;
        repeat (2) tick;
        chk("rst.grant", w_grant, 32'hFFFF_FFFF);
        chk("rst.state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst.strobes", 32'({w_mem_we, w_mem_le}), 32'h0);
        chk("rst.mem_addr", w_mem_addr, 32'h0);
        chk("rst.odata", w_req_odata, 32'h0);
        chk("rst.busy", 32'(w_req_busy), 32'h0);
        RST_X = 1'b1;
        tick;
        chk("idle_noreq.state", 32'(dbg_state), 32'(ST_IDLE));

        // Single read from hart 1, controller busy for 3 cycles.
        set_hart(1, 32'h8000_0010, 32'h0, 3'b010);
        w_req_le[1] = 1'b1;
        txn(1, 1'b0, 32'h8000_0010, 32'h0, 3'b010, 3, 32'hDEAD_BEEF, 1'b1, "rd_h1");

        // From reset: hart 0 write and hart 1 read together; hart 0 wins first.
        RST_X = 1'b0;
        tick;
        RST_X = 1'b1;
        tick;
        set_hart(0, 32'h8000_0000, 32'h1234_5678, 3'b010);
        set_hart(1, 32'h8000_0020, 32'h0, 3'b100);
        w_req_we[0] = 1'b1;
        w_req_le[1] = 1'b1;
        txn(0, 1'b1, 32'h8000_0000, 32'h1234_5678, 3'b010, 2, 32'h0000_0000, 1'b1, "sim_h0");
        txn(1, 1'b0, 32'h8000_0020, 32'h0, 3'b100, 1, 32'hA5A5_5A5A, 1'b1, "sim_h1");

        // Both harts requesting continuously: grants alternate 0,1,0,1,0,1.
        set_hart(0, 32'h8000_0100, 32'h0000_0000, 3'b010);
        set_hart(1, 32'h8000_0200, 32'h0BAD_F00D, 3'b010);
        w_req_le[0] = 1'b1;
        w_req_we[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0)
                txn(0, 1'b0, 32'h8000_0100, 32'h0, 3'b010, 1, 32'h1000_0000 + i, 1'b0, "rr_h0");
            else
                txn(1, 1'b1, 32'h8000_0200, 32'h0BAD_F00D, 3'b010, 1, 32'h1000_0000 + i, 1'b0,
                    "rr_h1");
        end
        w_req_we = '0;
        w_req_le = '0;
        tick;
        chk("after_rr.state", 32'(dbg_state), 32'(ST_IDLE));

        // Zero-latency controller: busy never rises.
        set_hart(0, 32'h8000_0300, 32'h0, 3'b010);
        w_req_le[0] = 1'b1;
        txn(0, 1'b0, 32'h8000_0300, 32'h0, 3'b010, 0, 32'hCAFE_F00D, 1'b1, "zl_h0");

        // we and le together resolve to a write.
        set_hart(0, 32'h8000_0400, 32'h5555_AAAA, 3'b001);
        w_req_we[0] = 1'b1;
        w_req_le[0] = 1'b1;
        txn(0, 1'b1, 32'h8000_0400, 32'h5555_AAAA, 3'b001, 1, 32'h0, 1'b1, "wele_h0");

        // Reset in the middle of WAIT aborts without re-issuing the strobe.
        set_hart(0, 32'h8000_0500, 32'h0, 3'b010);
        w_req_le[0] = 1'b1;
        tick;
        chk("rstw.issue_le", 32'(w_mem_le), 32'h1);
        w_req_le[0] = 1'b0;
        tick;
        chk("rstw.state_wait", 32'(dbg_state), 32'(ST_WAIT));
        w_mem_busy = 1'b1;
        RST_X = 1'b0;
        #1;
        chk("rstw.async_grant", w_grant, 32'hFFFF_FFFF);
        chk("rstw.async_state", 32'(dbg_state), 32'(ST_IDLE));
        w_mem_busy = 1'b0;
        tick;
        chk("rstw.grant", w_grant, 32'hFFFF_FFFF);
        chk("rstw.mem_le", 32'(w_mem_le), 32'h0);
        chk("rstw.state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rstw.busy", 32'(w_req_busy), 32'h0);
        RST_X = 1'b1;
        repeat (2) tick;
        chk("rstw.no_reissue", 32'({w_mem_we, w_mem_le}), 32'h0);
        chk("rstw.idle_after", 32'(dbg_state), 32'(ST_IDLE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Round-robin arbiter between NCORES cpummu instances and the single DRAM controller port.
- Sits directly downstream of each core's MMU DRAM interface (addr/wdata/we/le/ctrl, busy/odata).
- Drives the shared w_grant bus that every MMU compares against its own hart id.
- Serialises whole transactions: a grant is held from issue until the controller finishes and the hart has had one cycle to capture read data.

Parameters:
- NCORES, 2, number of requesting harts (1..8).
- GRANT_NONE, 32'hFFFFFFFF, w_grant value when no hart owns the port.

Ports:
- CLK  in  1  system clock.
- RST_X  in  1  asynchronous active-low reset.
- w_req_addr  in  NCORES*32  per-hart DRAM address; hart i occupies bits [32*i+31:32*i].
- w_req_wdata  in  NCORES*32  per-hart write data.
- w_req_ctrl  in  NCORES*3  per-hart size/sign control.
- w_req_we  in  NCORES  per-hart write request, level.
- w_req_le  in  NCORES  per-hart read request, level.
- w_req_busy  out  NCORES  per-hart busy returned to the MMU.
- w_req_odata  out  32  read data, broadcast to all harts.
- w_grant  out  32  hart id currently owning the port, or GRANT_NONE.
- w_mem_addr  out  32  address to the DRAM controller.
- w_mem_wdata  out  32  write data to the controller.
- w_mem_ctrl  out  3  size/sign control to the controller.
- w_mem_we  out  1  one-cycle write strobe.
- w_mem_le  out  1  one-cycle read strobe.
- w_mem_busy  in  1  controller busy.
- w_mem_odata  in  32  controller read data.

Behaviour:
- All outputs are registered. On reset: state IDLE, w_grant = GRANT_NONE, w_mem_we = w_mem_le = 0, w_mem_addr/wdata/ctrl = 0, w_req_odata = 0, rr pointer = NCORES-1.
- Reset is asynchronous; asserting it mid-transaction aborts immediately to the reset state. No strobe is re-issued.
- A hart requests when (w_req_we[i] | w_req_le[i]). If both are set, it is a write.
- FSM states:
  - IDLE: if any hart requests, pick the first requester searching from rr+1 modulo NCORES. Latch that hart's addr/wdata/ctrl/we/le onto w_mem_*, strobe we or le, set w_grant = i, set rr = i, go to ISSUE. With no requests, stay in IDLE.
  - ISSUE (1 cycle): deassert strobes, clear seen_busy, go to WAIT.
  - WAIT: set seen_busy when w_mem_busy = 1. When seen_busy = 1 and w_mem_busy = 0, latch w_req_odata = w_mem_odata and go to RELEASE.
  - RELEASE (1 cycle): w_grant is still held so the hart can capture data. Then set w_grant = GRANT_NONE and return to IDLE.
- The controller must raise busy within 2 cycles of the strobe. If w_mem_busy is sampled 0 in the first WAIT cycle and in the cycle after, WAIT treats the operation as zero-latency complete. seen_busy is forced on after 2 WAIT cycles.
- w_req_busy[i]:
  - granted hart: 1 in ISSUE and WAIT, 0 in RELEASE;
  - requesting but not granted: 1;
  - otherwise: 0.
- Request to first strobe latency: strobe is visible 1 cycle after the request is sampled in IDLE.
- A new request is never accepted in RELEASE, so back-to-back transactions are separated by at least one IDLE cycle.
- A hart dropping its request mid-transaction has no effect. The transaction completes.
- With all NCORES harts requesting continuously, each is served exactly once per NCORES grants (no starvation).

Decomposition:
- Shared package/define header holds: GRANT_NONE, the FSM state encodings (IDLE/ISSUE/WAIT/RELEASE, 2 bits), and the 3-bit ctrl width constant.
- One natural sub-module: rr_pick. It is a combinational round-robin priority encoder: request vector + last pointer in, next index + valid out.

Test Plan:
- Reset mid-WAIT (hart 0 read in flight, RST_X low 1 cycle) -> next cycle w_grant = 32'hFFFFFFFF, w_mem_le = 0, state IDLE, w_req_busy = 0.
- Single read, hart 1, addr 32'h8000_0010; controller busy 3 cycles, returns 32'hDEADBEEF -> w_mem_le pulse 1 cycle with that addr, w_grant = 1 through RELEASE, w_req_odata = 32'hDEADBEEF in RELEASE, w_req_busy[1] drops in RELEASE.
- Simultaneous write hart 0 (32'h8000_0000 <= 32'h1234_5678) and read hart 1 from reset -> hart 0 granted first (rr = 1 initially). Hart 1 is held busy, then granted after the RELEASE+IDLE of hart 0.
- Both harts requesting continuously for 6 transactions -> grant order 0,1,0,1,0,1.
- Zero-latency controller (w_mem_busy never asserted) -> transaction completes 2 WAIT cycles after ISSUE, and w_req_odata = the w_mem_odata value sampled then.
- Hart 0 sets we and le together -> w_mem_we = 1, w_mem_le = 0.
